// File: rtl/riscv_fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// A fetch buffer entry pairs an instruction word with the PC it was fetched from.
package riscv_fetch_pkg;

    localparam int              XLEN             = 32;
    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [XLEN-1:0] IMEM_WORD_BYTES  = 32'd4;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
    } fetch_entry_t;

    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/riscv_fetch_fifo.sv
// Small synchronous FIFO of fetch entries; flush wins over push and pop.
// Entries are cleared on reset so the head reads zero straight out of reset.
module riscv_fetch_fifo
    import riscv_fetch_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = PW + 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_push,
    input  logic         i_pop,
    input  logic         i_flush,
    input  fetch_entry_t i_data,
    output fetch_entry_t o_head,
    output logic [CW-1:0] o_count,
    output logic         o_empty,
    output logic         o_full
);

    fetch_entry_t  r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          w_do_push;
    logic          w_do_pop;

    assign o_count   = r_count;
    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == CW'(DEPTH));
    assign o_head    = r_mem[r_rd_ptr];
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
        end
    end

    // Request credits should make a push into a full buffer impossible.
    assert property (@(posedge clk) disable iff (!rst_n) !(i_push && !i_flush && o_full));

endmodule

// File: rtl/riscv_fetch.sv
// Fetch stage: owns the fetch PC, issues credit-limited word reads and buffers
// returned instructions for decode; redirects flush the buffer and drop stale responses.
module riscv_fetch
    import riscv_fetch_pkg::*;
#(
    parameter int                     WORD_LENGTH = XLEN,
    parameter logic [WORD_LENGTH-1:0] RESET_PC    = DEFAULT_RESET_PC,
    parameter int                     FIFO_DEPTH  = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    output logic                   imem_req_valid,
    input  logic                   imem_req_ready,
    output logic [WORD_LENGTH-1:0] imem_req_addr,
    input  logic                   imem_resp_valid,
    input  logic [WORD_LENGTH-1:0] imem_resp_data,
    input  logic                   redirect_valid,
    input  logic [WORD_LENGTH-1:0] redirect_pc,
    output logic                   inst_valid,
    input  logic                   inst_ready,
    output logic [WORD_LENGTH-1:0] inst,
    output logic [WORD_LENGTH-1:0] inst_pc
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [WORD_LENGTH-1:0] r_fetch_pc;
    logic [WORD_LENGTH-1:0] r_resp_pc;
    logic [CW-1:0]          r_inflight;
    logic [CW-1:0]          r_drop_cnt;

    logic [CW-1:0]          w_fifo_count;
    logic [CW:0]            w_credit_used;
    logic                   w_fifo_empty;
    logic                   w_fifo_full;
    logic                   w_req_valid;
    logic                   w_req_fire;
    logic                   w_resp_drop;
    logic                   w_push;
    logic                   w_pop;
    logic [WORD_LENGTH-1:0] w_target;
    fetch_entry_t           w_push_entry;
    fetch_entry_t           w_head;

    // Outstanding requests plus buffered entries never exceed the buffer size,
    // so every response is guaranteed a free slot.
    assign w_credit_used = {1'b0, r_inflight} + {1'b0, w_fifo_count};
    assign w_req_valid   = rst_n && (w_credit_used < (CW+1)'(FIFO_DEPTH)) && !redirect_valid;
    assign w_req_fire    = w_req_valid && imem_req_ready;
    assign w_resp_drop   = imem_resp_valid && (r_drop_cnt != '0);
    assign w_push        = imem_resp_valid && (r_drop_cnt == '0) && !redirect_valid;
    assign w_pop         = inst_valid && inst_ready;
    assign w_target      = word_align(redirect_pc);
    assign w_push_entry  = '{pc: r_resp_pc, inst: imem_resp_data};

    assign imem_req_valid = w_req_valid;
    assign imem_req_addr  = r_fetch_pc;
    assign inst_valid     = !w_fifo_empty;
    assign inst           = w_fifo_empty ? '0 : w_head.inst;
    assign inst_pc        = w_fifo_empty ? '0 : w_head.pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fetch_pc <= RESET_PC;
            r_resp_pc  <= RESET_PC;
            r_inflight <= '0;
            r_drop_cnt <= '0;
        end else if (redirect_valid) begin
            // Everything still outstanding after this cycle belongs to the old stream.
            r_fetch_pc <= w_target;
            r_resp_pc  <= w_target;
            r_inflight <= r_inflight - CW'(imem_resp_valid);
            r_drop_cnt <= r_inflight - CW'(imem_resp_valid);
        end else begin
            if (w_req_fire) begin
                r_fetch_pc <= r_fetch_pc + IMEM_WORD_BYTES;
            end
            if (w_push) begin
                r_resp_pc <= r_resp_pc + IMEM_WORD_BYTES;
            end
            if (w_resp_drop) begin
                r_drop_cnt <= r_drop_cnt - 1'b1;
            end
            r_inflight <= r_inflight + CW'(w_req_fire) - CW'(imem_resp_valid);
        end
    end

    riscv_fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (redirect_valid),
        .i_data  (w_push_entry),
        .o_head  (w_head),
        .o_count (w_fifo_count),
        .o_empty (w_fifo_empty),
        .o_full  (w_fifo_full)
    );

    logic w_unused;
    assign w_unused = w_fifo_full;

endmodule

// File: tb/tb_riscv_fetch.sv
// Directed bench for riscv_fetch with a fixed-latency instruction memory model.
module tb_riscv_fetch;

    logic        clk;
    logic        rst_n;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;

    int checks   = 0;
    int failures = 0;
    int mem_lat  = 1;

    logic [31:0] req_q[$];
    logic [31:0] dec_pc_q[$];
    logic [31:0] dec_inst_q[$];

    logic [3:0]  r_sv;
    logic [31:0] r_sa [4];

    riscv_fetch dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .inst_valid      (inst_valid),
        .inst_ready      (inst_ready),
        .inst            (inst),
        .inst_pc         (inst_pc)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sv <= '0;
        end else begin
            r_sv    <= {r_sv[2:0], imem_req_valid && imem_req_ready};
            r_sa[0] <= imem_req_addr;
            r_sa[1] <= r_sa[0];
            r_sa[2] <= r_sa[1];
            r_sa[3] <= r_sa[2];
        end
    end
    assign imem_resp_valid = r_sv[mem_lat-1];
    assign imem_resp_data  = mem_word(r_sa[mem_lat-1]);

    always @(posedge clk) begin
        if (rst_n) begin
            if (imem_req_valid && imem_req_ready) req_q.push_back(imem_req_addr);
            if (inst_valid && inst_ready && !redirect_valid) begin
                dec_pc_q.push_back(inst_pc);
                dec_inst_q.push_back(inst);
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] qget(input int which, input int idx);
        logic [31:0] v;
        v = 'x;
        case (which)
            0: if (idx < req_q.size())      v = req_q[idx];
            1: if (idx < dec_pc_q.size())   v = dec_pc_q[idx];
            default: if (idx < dec_inst_q.size()) v = dec_inst_q[idx];
        endcase
        return v;
    endfunction

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_q();
        req_q.delete();
        dec_pc_q.delete();
        dec_inst_q.delete();
    endtask

    task automatic do_reset(input int lat, input logic rdy);
        @(negedge clk);
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        imem_req_ready = 1'b1;
        inst_ready     = rdy;
        mem_lat        = lat;
        step(2);
        clear_q();
        rst_n = 1'b1;
        #1;
    endtask

    task automatic redirect(input logic [31:0] pc);
        redirect_pc    = pc;
        redirect_valid = 1'b1;
        clear_q();
        #1;
        check("redir_no_req", {31'b0, imem_req_valid}, 32'd0);
        step(1);
        redirect_valid = 1'b0;
        #1;
    endtask

    initial begin
        rst_n          = 1'b0;
        imem_req_ready = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        inst_ready     = 1'b0;
        step(1);
        #1;
        check("rst_inst_valid", {31'b0, inst_valid}, 32'd0);
        check("rst_req_valid",  {31'b0, imem_req_valid}, 32'd0);
        check("rst_inst",       inst, 32'd0);
        check("rst_inst_pc",    inst_pc, 32'd0);

        // 1: streaming with a 1-cycle memory
        do_reset(1, 1'b1);
        check("t1_req_valid0", {31'b0, imem_req_valid}, 32'd1);
        check("t1_addr0",      imem_req_addr, 32'h0);
        step(1); #1;
        check("t1_no_inst_n1", {31'b0, inst_valid}, 32'd0);
        check("t1_addr1",      imem_req_addr, 32'h4);
        step(1); #1;
        check("t1_inst_valid_n2", {31'b0, inst_valid}, 32'd1);
        check("t1_inst_pc_n2",    inst_pc, 32'h0);
        check("t1_inst_n2",       inst, mem_word(32'h0));
        check("t1_credit_full",   {31'b0, imem_req_valid}, 32'd0);
        step(16);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t1_req%0d", i), qget(0, i), 32'(i * 4));
            check($sformatf("t1_pc%0d", i),  qget(1, i), 32'(i * 4));
            check($sformatf("t1_dat%0d", i), qget(2, i), mem_word(32'(i * 4)));
        end

        // 2: decode stalled, buffer fills, then drains in order
        do_reset(1, 1'b0);
        step(10); #1;
        check("t2_req_count", 32'(req_q.size()), 32'd2);
        check("t2_req_valid", {31'b0, imem_req_valid}, 32'd0);
        check("t2_inst_valid", {31'b0, inst_valid}, 32'd1);
        check("t2_head_pc", inst_pc, 32'h0);
        inst_ready = 1'b1;
        step(1); #1;
        check("t2_second_pc", inst_pc, 32'h4);
        check("t2_second_dat", inst, mem_word(32'h4));
        step(1);
        check("t2_pop_count", 32'(dec_pc_q.size()), 32'd2);
        check("t2_pop0", qget(1, 0), 32'h0);
        check("t2_pop1", qget(1, 1), 32'h4);

        // 3: redirect with two requests outstanding (3-cycle memory)
        do_reset(3, 1'b1);
        step(2); #1;
        check("t3_inflight_stall", {31'b0, imem_req_valid}, 32'd0);
        check("t3_req_count", 32'(req_q.size()), 32'd2);
        redirect(32'h0000_0100);
        step(20);
        check("t3_first_req", qget(0, 0), 32'h100);
        check("t3_first_pc",  qget(1, 0), 32'h100);
        check("t3_first_dat", qget(2, 0), mem_word(32'h100));
        check("t3_second_pc", qget(1, 1), 32'h104);

        // 4: redirect while a response arrives in the same cycle (2-cycle memory)
        do_reset(2, 1'b1);
        step(2); #1;
        check("t4_resp_this_cycle", {31'b0, imem_resp_valid}, 32'd1);
        redirect(32'h0000_0200);
        check("t4_req_next", {31'b0, imem_req_valid}, 32'd1);
        check("t4_addr_next", imem_req_addr, 32'h200);
        step(12);
        check("t4_first_pc",  qget(1, 0), 32'h200);
        check("t4_first_dat", qget(2, 0), mem_word(32'h200));
        check("t4_second_pc", qget(1, 1), 32'h204);

        // 5: PC wrap and misaligned redirect target
        redirect(32'hFFFF_FFFC);
        step(12);
        check("t5_req0", qget(0, 0), 32'hFFFF_FFFC);
        check("t5_req1", qget(0, 1), 32'h0000_0000);
        check("t5_pc0",  qget(1, 0), 32'hFFFF_FFFC);
        check("t5_pc1",  qget(1, 1), 32'h0000_0000);
        check("t5_dat1", qget(2, 1), mem_word(32'h0));
        redirect(32'h0000_0103);
        check("t5_align_addr", imem_req_addr, 32'h100);
        step(10);
        check("t5_align_req", qget(0, 0), 32'h100);
        check("t5_align_pc",  qget(1, 0), 32'h100);

        // 6: reset asserted with a full buffer
        do_reset(1, 1'b0);
        step(6); #1;
        check("t6_full_valid", {31'b0, inst_valid}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("t6_rst_inst_valid", {31'b0, inst_valid}, 32'd0);
        check("t6_rst_req_valid",  {31'b0, imem_req_valid}, 32'd0);
        check("t6_rst_inst_pc",    inst_pc, 32'd0);
        step(1);
        clear_q();
        inst_ready = 1'b1;
        rst_n = 1'b1;
        #1;
        check("t6_restart_valid", {31'b0, imem_req_valid}, 32'd1);
        check("t6_restart_addr",  imem_req_addr, 32'h0);
        step(8);
        check("t6_restart_pc", qget(1, 0), 32'h0);

        // 7: request address held while memory is not ready
        do_reset(1, 1'b1);
        imem_req_ready = 1'b0;
        step(4); #1;
        check("t7_hold_valid", {31'b0, imem_req_valid}, 32'd1);
        check("t7_hold_addr",  imem_req_addr, 32'h0);
        check("t7_no_accept",  32'(req_q.size()), 32'd0);
        imem_req_ready = 1'b1;
        step(1); #1;
        check("t7_advance_addr", imem_req_addr, 32'h4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
